// File: rtl/vm_button_conditioner.sv
// Push-button front end: 2-FF sync, debounce, rise detect and fixed-priority arbitration.
// Optional `VM_BTN_HOLDOFF_EN` inserts HOLDOFF_CYC dead cycles after each emitted pulse.
module vm_button_conditioner #(
   parameter int unsigned DB_CYC      = 4,
   parameter int unsigned HOLDOFF_CYC = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_btn_coin,
   input  logic       i_btn_coffee,
   input  logic       i_btn_sprite,
   output logic       o_coin,
   output logic       o_coffee,
   output logic       o_sprite,
   output logic [2:0] o_stable,
   output logic [2:0] o_pending
);

   localparam int unsigned CW = $clog2(DB_CYC + 1);
   localparam logic [CW-1:0] DB_LAST = CW'(DB_CYC - 1);

   if (DB_CYC < 1) begin : g_bad_db_cyc
      $error("DB_CYC must be at least 1");
   end
   if (HOLDOFF_CYC < 1) begin : g_bad_holdoff_cyc
      $error("HOLDOFF_CYC must be at least 1");
   end

   logic [2:0] btn_raw;
   logic [2:0] sync1_q;
   logic [2:0] sync2_q;
   logic [2:0] stable;
   logic [2:0] stable_prev_q;
   logic [2:0] pending_q;
   logic [2:0] pending_d;
   logic [2:0] pulse_q;
   logic [2:0] pulse_d;
   logic [2:0] rise;
   logic [2:0] req;
   logic [2:0] grant;
   logic       hold_busy;

   // Bit order everywhere is {sprite, coffee, coin}.
   assign btn_raw = {i_btn_sprite, i_btn_coffee, i_btn_coin};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
      end
   end

   for (genvar ch = 0; ch < 3; ch++) begin : g_db
      logic [CW-1:0] cnt_q;
      logic          stable_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
         end else if (sync2_q[ch] == stable_q) begin
            cnt_q <= '0;
         end else if (cnt_q == DB_LAST) begin
            cnt_q    <= '0;
            stable_q <= sync2_q[ch];
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end

      assign stable[ch] = stable_q;
   end

   assign rise = stable & ~stable_prev_q;
   assign req  = rise | pending_q;

   always_comb begin
      grant = 3'b000;
      if (req[0]) begin
         grant = 3'b001;
      end else if (req[1]) begin
         grant = 3'b010;
      end else if (req[2]) begin
         grant = 3'b100;
      end
   end

`ifdef VM_BTN_HOLDOFF_EN
   localparam int unsigned HW = $clog2(HOLDOFF_CYC + 1);

   logic [HW-1:0] hold_q;

   assign hold_busy = (hold_q != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q <= '0;
      end else if (|pulse_d) begin
         hold_q <= HW'(HOLDOFF_CYC);
      end else if (hold_busy) begin
         hold_q <= hold_q - HW'(1);
      end
   end
`else
   assign hold_busy = 1'b0;
`endif

   // While held off every request, fresh or old, parks in pending.
   always_comb begin
      pulse_d   = 3'b000;
      pending_d = req;
      if (!hold_busy) begin
         pulse_d   = grant;
         pending_d = req & ~grant;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stable_prev_q <= '0;
         pending_q     <= '0;
         pulse_q       <= '0;
      end else begin
         stable_prev_q <= stable;
         pending_q     <= pending_d;
         pulse_q       <= pulse_d;
      end
   end

   assign o_coin    = pulse_q[0];
   assign o_coffee  = pulse_q[1];
   assign o_sprite  = pulse_q[2];
   assign o_stable  = stable;
   assign o_pending = pending_q;

endmodule

// File: tb/tb_vm_button_conditioner.sv
// Self-checking bench: directed scenarios plus random button activity against a window-based model.
module tb_vm_button_conditioner;

   localparam int unsigned DB_CYC      = 4;
   localparam int unsigned HOLDOFF_CYC = 2;
`ifdef VM_BTN_HOLDOFF_EN
   localparam int GAP = HOLDOFF_CYC;
`else
   localparam int GAP = 0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] btn;
   logic       o_coin, o_coffee, o_sprite;
   logic [2:0] o_stable, o_pending;

   int n_cmp = 0;
   int n_err = 0;
   int n_pulse [3];
   logic [2:0] obs;

   vm_button_conditioner #(
      .DB_CYC      (DB_CYC),
      .HOLDOFF_CYC (HOLDOFF_CYC)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_btn_coin   (btn[0]),
      .i_btn_coffee (btn[1]),
      .i_btn_sprite (btn[2]),
      .o_coin       (o_coin),
      .o_coffee     (o_coffee),
      .o_sprite     (o_sprite),
      .o_stable     (o_stable),
      .o_pending    (o_pending)
   );

   always #5 clk = ~clk;

   // Reference model: synchronizer as a 2-deep delay, debounce as "last DB_CYC samples all
   // disagree with stable", arbitration as lowest set bit subject to a minimum pulse spacing.
   bit [2:0] m_s1, m_s2, m_stable, m_stable_prev, m_pending, m_pulse;
   bit [2:0] m_hist [$];
   int       m_edge;
   int       m_last_pulse;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_s1 = 0; m_s2 = 0; m_stable = 0; m_stable_prev = 0; m_pending = 0; m_pulse = 0;
      m_hist.delete();
      m_last_pulse = -1000000;
   endtask

   task automatic model_step(input bit [2:0] raw);
      bit [2:0] req;
      bit [2:0] nxt_pulse;
      bit [2:0] nxt_pending;
      bit [2:0] nxt_stable;
      bit       all_diff;
      req         = (m_stable & ~m_stable_prev) | m_pending;
      nxt_pulse   = 0;
      nxt_pending = req;
      if (req != 0 && (m_edge - m_last_pulse) > GAP) begin
         for (int i = 0; i < 3; i++) begin
            if (req[i]) begin
               nxt_pulse[i]   = 1'b1;
               nxt_pending[i] = 1'b0;
               m_last_pulse   = m_edge;
               break;
            end
         end
      end
      m_hist.push_back(m_s2);
      if (m_hist.size() > DB_CYC) void'(m_hist.pop_front());
      nxt_stable = m_stable;
      if (m_hist.size() == DB_CYC) begin
         for (int c = 0; c < 3; c++) begin
            all_diff = 1'b1;
            foreach (m_hist[j]) if (m_hist[j][c] == m_stable[c]) all_diff = 1'b0;
            if (all_diff) nxt_stable[c] = ~m_stable[c];
         end
      end
      m_stable_prev = m_stable;
      m_stable      = nxt_stable;
      m_s2          = m_s1;
      m_s1          = raw;
      m_pulse       = nxt_pulse;
      m_pending     = nxt_pending;
      m_edge++;
   endtask

   task automatic compare_all();
      check_val("pulse", {29'd0, obs}, {29'd0, m_pulse});
      check_val("stable", {29'd0, o_stable}, {29'd0, m_stable});
      check_val("pending", {29'd0, o_pending}, {29'd0, m_pending});
      check_val("onehot", 32'($countones(obs) <= 1), 32'd1);
   endtask

   // One clock: account for the edge just passed, compare, then drive the next input.
   task automatic run_cycle(input logic [2:0] nxt);
      @(negedge clk);
      if (!rst_n) model_reset();
      else model_step(btn);
      obs = {o_sprite, o_coffee, o_coin};
      compare_all();
      for (int i = 0; i < 3; i++) if (obs[i]) n_pulse[i]++;
      btn = nxt;
   endtask

   task automatic run_n(input int n);
      for (int i = 0; i < n; i++) run_cycle(btn);
   endtask

   task automatic do_reset(input int n);
      run_cycle(btn);
      rst_n = 1'b0;
      #1;
      model_reset();
      check_val("reset_out", {23'd0, o_coin, o_coffee, o_sprite, o_stable, o_pending}, 32'd0);
      run_n(n);
      rst_n = 1'b1;
   endtask

   // Counts edges until channel ch pulses; returns budget+1 on timeout.
   task automatic wait_pulse(input int ch, input int budget, output int k);
      k = 0;
      for (int i = 1; i <= budget; i++) begin
         run_cycle(btn);
         if (obs[ch]) begin
            k = i;
            return;
         end
      end
      k = budget + 1;
   endtask

   initial begin
      int k;
      int base [3];
      logic [2:0] lvl;
      int hold [3];

      for (int i = 0; i < 3; i++) n_pulse[i] = 0;
      m_edge = 0;
      rst_n = 1'b0;
      btn   = 3'b000;
      model_reset();
      #1;
      check_val("reset_out", {23'd0, o_coin, o_coffee, o_sprite, o_stable, o_pending}, 32'd0);
      run_n(3);
      rst_n = 1'b1;
      run_n(4);

      // 1: single coin press held, one pulse with fixed latency
      base[0] = n_pulse[0];
      run_cycle(3'b001);
      wait_pulse(0, 40, k);
      check_val("t1_latency", k, DB_CYC + 3);
      run_n(18);
      check_val("t1_count", n_pulse[0] - base[0], 1);
      check_val("t1_stable", {29'd0, o_stable}, 32'd1);
      run_cycle(3'b000);
      run_n(12);

      // 2: coffee glitch shorter than DB_CYC
      base[1] = n_pulse[1];
      run_cycle(3'b010);
      run_n(2);
      run_cycle(3'b000);
      run_n(15);
      check_val("t2_count", n_pulse[1] - base[1], 0);
      check_val("t2_stable", {31'd0, o_stable[1]}, 32'd0);
      check_val("t2_pending", {29'd0, o_pending}, 32'd0);

      // 3/4: coin and sprite together, sprite follows after GAP dead cycles
      run_cycle(3'b101);
      wait_pulse(0, 40, k);
      check_val("t3_coin_latency", k, DB_CYC + 3);
      check_val("t3_pending", {29'd0, o_pending}, 32'h4);
      wait_pulse(2, 20, k);
      check_val("t3_sprite_gap", k, GAP + 1);
      run_n(3);
      check_val("t3_pending_clr", {29'd0, o_pending}, 32'd0);
      run_cycle(3'b000);
      run_n(12);

      // 5: reset mid-debounce while coffee held
      base[1] = n_pulse[1];
      run_cycle(3'b010);
      run_n(3);
      do_reset(1);
      wait_pulse(1, 40, k);
      check_val("t5_latency", k, DB_CYC + 3);
      run_n(20);
      check_val("t5_count", n_pulse[1] - base[1], 1);
      run_cycle(3'b000);
      run_n(12);

      // 6: two separate coin presses
      for (int i = 0; i < 3; i++) base[i] = n_pulse[i];
      run_cycle(3'b001);
      run_n(9);
      run_cycle(3'b000);
      run_n(9);
      run_cycle(3'b001);
      run_n(9);
      run_cycle(3'b000);
      run_n(12);
      check_val("t6_coin", n_pulse[0] - base[0], 2);
      check_val("t6_others", n_pulse[1] - base[1] + n_pulse[2] - base[2], 0);

      // Random activity with glitches, overlaps and occasional resets
      lvl = 3'b000;
      for (int i = 0; i < 3; i++) hold[i] = $urandom_range(1, 12);
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 3; i++) begin
            hold[i]--;
            if (hold[i] <= 0) begin
               lvl[i]  = ~lvl[i];
               hold[i] = $urandom_range(1, 12);
            end
         end
         if ($urandom_range(0, 399) == 0) begin
            btn = lvl;
            do_reset($urandom_range(1, 2));
         end else begin
            run_cycle(lvl);
         end
      end
      run_n(5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
